// File: rtl/data_path.sv
// ---------------------------------------------------------------------------
// data_path
// Single-bus 32-bit processor datapath: register file R1..R15, special
// registers (PC, IR, MAR, MDR, Y, HI, LO, C), a 64-bit Z register and a
// combinational ALU whose operands are Y (A) and the bus (B).
//
// Ports
//   Clock                  sole clock, rising edge
//   Clear                  asynchronous active-low reset of every register
//   PCout..R7out           bus-drive enables (fixed priority, see bus mux)
//   MARin..Cin, R1in..R15in, ZHighIn, ZLowIn   register load enables
//   IncPC                  PC increment, wins over PCin
//   Read                   MDR source: 1 = Mdatain, 0 = bus
//   SHRA                   5-bit ALU operation select
//   Mdatain                32-bit memory read data
// There are no output ports; state is observed through the internal
// registers.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module data_path (
  input logic        Clock,
  input logic        Clear,
  input logic        PCout,
  input logic        ZHighout,
  input logic        Zlowout,
  input logic        MDRout,
  input logic        R2out,
  input logic        R3out,
  input logic        R4out,
  input logic        R5out,
  input logic        R6out,
  input logic        R7out,
  input logic        MARin,
  input logic        PCin,
  input logic        MDRin,
  input logic        IRin,
  input logic        Yin,
  input logic        HIin,
  input logic        LOin,
  input logic        Cin,
  input logic        R1in,
  input logic        R2in,
  input logic        R3in,
  input logic        R4in,
  input logic        R5in,
  input logic        R6in,
  input logic        R7in,
  input logic        R8in,
  input logic        R9in,
  input logic        R10in,
  input logic        R11in,
  input logic        R12in,
  input logic        R13in,
  input logic        R14in,
  input logic        R15in,
  input logic        ZHighIn,
  input logic        ZLowIn,
  input logic        IncPC,
  input logic        Read,
  input logic [4:0]  SHRA,
  input logic [31:0] Mdatain
);

  logic [31:0] pc, ir, mar, mdr, y, hi, lo, c;
  logic [63:0] z;
  logic [31:0] r [1:15];

  logic [15:1] r_load;
  logic [31:0] bus;
  logic [63:0] alu_result;

  assign r_load = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                   R7in, R6in, R5in, R4in, R3in, R2in, R1in};

  // Bus source mux, highest priority first; an idle bus reads as zero.
  always_comb begin
    bus = '0;
    if (ZHighout)     bus = z[63:32];
    else if (Zlowout) bus = z[31:0];
    else if (MDRout)  bus = mdr;
    else if (PCout)   bus = pc;
    else if (R2out)   bus = r[2];
    else if (R3out)   bus = r[3];
    else if (R4out)   bus = r[4];
    else if (R5out)   bus = r[5];
    else if (R6out)   bus = r[6];
    else if (R7out)   bus = r[7];
  end

  // ALU: A = Y, B = bus. Rotates use a doubled copy of A so a plain shift
  // yields the rotated word. Division is done at 33 bits so that
  // -2^31 / -1 cannot overflow.
  logic [4:0]         amt;
  logic [63:0]        rot_r, rot_l, prod;
  logic [31:0]        sra;
  logic signed [32:0] div_a, div_b, quo, rem;

  always_comb begin
    amt   = bus[4:0];
    rot_r = {y, y} >> amt;
    rot_l = {y, y} << amt;
    sra   = $unsigned($signed(y) >>> amt);
    prod  = $signed({{32{y[31]}}, y}) * $signed({{32{bus[31]}}, bus});
    div_a = $signed({y[31], y});
    div_b = $signed({bus[31], bus});
    quo   = '0;
    rem   = '0;
    if (bus != 32'd0) begin
      quo = div_a / div_b;
      rem = div_a % div_b;
    end
    alu_result = '0;
    case (SHRA)
      5'b00011: alu_result = {32'd0, y + bus};
      5'b00100: alu_result = {32'd0, y - bus};
      5'b00101: alu_result = {32'd0, y >> amt};
      5'b00110: alu_result = {32'd0, sra};
      5'b00111: alu_result = {32'd0, y << amt};
      5'b01000: alu_result = {32'd0, rot_r[31:0]};
      5'b01001: alu_result = {32'd0, rot_l[63:32]};
      5'b01010: alu_result = {32'd0, y & bus};
      5'b01011: alu_result = {32'd0, y | bus};
      5'b01111: alu_result = prod;
      5'b10000: alu_result = {rem[31:0], quo[31:0]};
      5'b10001: alu_result = {32'd0, 32'd0 - bus};
      5'b10010: alu_result = {32'd0, ~bus};
      default:  alu_result = '0;
    endcase
  end

  // Register updates. Every register samples the pre-edge bus, so a
  // register that drives and loads in the same cycle keeps its old value.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      pc  <= '0;
      ir  <= '0;
      mar <= '0;
      mdr <= '0;
      y   <= '0;
      hi  <= '0;
      lo  <= '0;
      c   <= '0;
      z   <= '0;
      for (int k = 1; k <= 15; k++) r[k] <= '0;
    end else begin
      if (IncPC)     pc <= pc + 32'd1;
      else if (PCin) pc <= bus;
      if (MDRin)     mdr <= Read ? Mdatain : bus;
      if (IRin)      ir  <= bus;
      if (MARin)     mar <= bus;
      if (Yin)       y   <= bus;
      if (HIin)      hi  <= bus;
      if (LOin)      lo  <= bus;
      if (Cin)       c   <= bus;
      if (ZLowIn)    z[31:0]  <= alu_result[31:0];
      if (ZHighIn)   z[63:32] <= alu_result[63:32];
      for (int k = 1; k <= 15; k++)
        if (r_load[k]) r[k] <= bus;
    end
  end

endmodule

// File: tb/tb_data_path.sv
// ---------------------------------------------------------------------------
// tb_data_path
// Scoreboard bench for data_path. The driver issues one micro-operation per
// cycle, advances a behavioural register model and queues the expected
// contents of every register; a separate monitor drains the queue and
// compares against the design's internal registers.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_data_path;

  logic        Clock = 1'b0;
  logic        Clear = 1'b1;
  logic        pc_out, zh_out, zl_out, mdr_out;
  logic [7:2]  r_out;
  logic        mar_in, pc_in, mdr_in, ir_in, y_in, hi_in, lo_in, c_in;
  logic [15:1] r_in;
  logic        zh_in, zl_in, inc_pc, rd;
  logic [4:0]  op;
  logic [31:0] mdata;

  typedef struct {
    logic        pc_out, zh_out, zl_out, mdr_out;
    logic [7:2]  r_out;
    logic        mar_in, pc_in, mdr_in, ir_in, y_in, hi_in, lo_in, c_in;
    logic [15:1] r_in;
    logic        zh_in, zl_in, inc_pc, rd;
    logic [4:0]  op;
    logic [31:0] mdata;
  } ctrl_t;

  typedef struct {
    int          id;
    logic [31:0] val;
    string       tag;
  } exp_t;

  // Register indices: 0 PC,1 IR,2 MAR,3 MDR,4 Y,5 HI,6 LO,7 C,8 ZL,9 ZH,
  // 10..24 R1..R15.
  localparam int NREG = 25;
  logic [31:0] m [0:NREG-1];
  exp_t        exp_q [$];
  int          n_vec = 0;
  int          n_bad = 0;
  bit          done  = 0;

  data_path dut (
    .Clock(Clock), .Clear(Clear),
    .PCout(pc_out), .ZHighout(zh_out), .Zlowout(zl_out), .MDRout(mdr_out),
    .R2out(r_out[2]), .R3out(r_out[3]), .R4out(r_out[4]),
    .R5out(r_out[5]), .R6out(r_out[6]), .R7out(r_out[7]),
    .MARin(mar_in), .PCin(pc_in), .MDRin(mdr_in), .IRin(ir_in), .Yin(y_in),
    .HIin(hi_in), .LOin(lo_in), .Cin(c_in),
    .R1in(r_in[1]), .R2in(r_in[2]), .R3in(r_in[3]), .R4in(r_in[4]),
    .R5in(r_in[5]), .R6in(r_in[6]), .R7in(r_in[7]), .R8in(r_in[8]),
    .R9in(r_in[9]), .R10in(r_in[10]), .R11in(r_in[11]), .R12in(r_in[12]),
    .R13in(r_in[13]), .R14in(r_in[14]), .R15in(r_in[15]),
    .ZHighIn(zh_in), .ZLowIn(zl_in), .IncPC(inc_pc), .Read(rd),
    .SHRA(op), .Mdatain(mdata)
  );

  always #5 Clock = ~Clock;

  function automatic string reg_name(input int id);
    case (id)
      0: return "PC";   1: return "IR";  2: return "MAR"; 3: return "MDR";
      4: return "Y";    5: return "HI";  6: return "LO";  7: return "C";
      8: return "ZLO";  9: return "ZHI";
      default: return $sformatf("R%0d", id - 9);
    endcase
  endfunction

  function automatic logic [31:0] dut_val(input int id);
    case (id)
      0: return dut.pc;   1: return dut.ir;  2: return dut.mar;
      3: return dut.mdr;  4: return dut.y;   5: return dut.hi;
      6: return dut.lo;   7: return dut.c;
      8: return dut.z[31:0];
      9: return dut.z[63:32];
      default: return dut.r[id - 9];
    endcase
  endfunction

  // Reference ALU computed straight from the operation definitions.
  function automatic logic [63:0] model_alu(input logic [4:0] f,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    int unsigned ua, ub;
    int          sa, sb, sh;
    longint      ma, mb, q, r, p;
    ua = a; ub = b; sa = a; sb = b; sh = int'(b[4:0]);
    case (f)
      5'd3:  return {32'd0, 32'(ua + ub)};
      5'd4:  return {32'd0, 32'(ua - ub)};
      5'd5:  return {32'd0, 32'(ua >> sh)};
      5'd6:  return {32'd0, 32'(sa >>> sh)};
      5'd7:  return {32'd0, 32'(ua << sh)};
      5'd8:  return {32'd0, (sh == 0) ? a : 32'((ua >> sh) | (ua << (32 - sh)))};
      5'd9:  return {32'd0, (sh == 0) ? a : 32'((ua << sh) | (ua >> (32 - sh)))};
      5'd10: return {32'd0, a & b};
      5'd11: return {32'd0, a | b};
      5'd15: begin
        p = longint'(sa) * longint'(sb);
        return p;
      end
      5'd16: begin
        if (b == 32'd0) return 64'd0;
        ma = (sa < 0) ? -longint'(sa) : longint'(sa);
        mb = (sb < 0) ? -longint'(sb) : longint'(sb);
        q = ma / mb;
        r = ma - q * mb;
        if ((sa < 0) != (sb < 0)) q = -q;
        if (sa < 0) r = -r;
        return {r[31:0], q[31:0]};
      end
      5'd17: return {32'd0, 32'(0 - ub)};
      5'd18: return {32'd0, ~b};
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_bus(input ctrl_t s);
    if (s.zh_out)  return m[9];
    if (s.zl_out)  return m[8];
    if (s.mdr_out) return m[3];
    if (s.pc_out)  return m[0];
    for (int k = 2; k <= 7; k++)
      if (s.r_out[k]) return m[9 + k];
    return 32'd0;
  endfunction

  task automatic model_step(input ctrl_t s);
    logic [31:0] b, nm [0:NREG-1];
    logic [63:0] res;
    b   = model_bus(s);
    res = model_alu(s.op, m[4], b);
    nm  = m;
    if (s.inc_pc)     nm[0] = m[0] + 32'd1;
    else if (s.pc_in) nm[0] = b;
    if (s.ir_in)  nm[1] = b;
    if (s.mar_in) nm[2] = b;
    if (s.mdr_in) nm[3] = s.rd ? s.mdata : b;
    if (s.y_in)   nm[4] = b;
    if (s.hi_in)  nm[5] = b;
    if (s.lo_in)  nm[6] = b;
    if (s.c_in)   nm[7] = b;
    if (s.zl_in)  nm[8] = res[31:0];
    if (s.zh_in)  nm[9] = res[63:32];
    for (int k = 1; k <= 15; k++)
      if (s.r_in[k]) nm[9 + k] = b;
    m = nm;
  endtask

  function automatic ctrl_t idle();
    ctrl_t s;
    s = '{default: '0};
    return s;
  endfunction

  task automatic push_all(input string tag);
    for (int i = 0; i < NREG; i++) exp_q.push_back('{i, m[i], tag});
  endtask

  task automatic expect_const(input int id, input logic [31:0] v, input string tag);
    exp_q.push_back('{id, v, tag});
  endtask

  // One clock of stimulus; the model only advances while Clear is high.
  task automatic applyStimulus(input ctrl_t s);
    @(negedge Clock);
    pc_out = s.pc_out; zh_out = s.zh_out; zl_out = s.zl_out; mdr_out = s.mdr_out;
    r_out = s.r_out; mar_in = s.mar_in; pc_in = s.pc_in; mdr_in = s.mdr_in;
    ir_in = s.ir_in; y_in = s.y_in; hi_in = s.hi_in; lo_in = s.lo_in;
    c_in = s.c_in; r_in = s.r_in; zh_in = s.zh_in; zl_in = s.zl_in;
    inc_pc = s.inc_pc; rd = s.rd; op = s.op; mdata = s.mdata;
    if (Clear) model_step(s);
    @(posedge Clock);
    #1;
    push_all("step");
  endtask

  task automatic load_mdr(input logic [31:0] v);
    ctrl_t s;
    s = idle(); s.mdr_in = 1; s.rd = 1; s.mdata = v;
    applyStimulus(s);
  endtask

  task automatic set_y(input logic [31:0] v);
    ctrl_t s;
    load_mdr(v);
    s = idle(); s.mdr_out = 1; s.y_in = 1;
    applyStimulus(s);
  endtask

  task automatic set_r(input int k, input logic [31:0] v);
    ctrl_t s;
    load_mdr(v);
    s = idle(); s.mdr_out = 1; s.r_in[k] = 1;
    applyStimulus(s);
  endtask

  task automatic alu_r3(input logic [4:0] f, input logic hi_too);
    ctrl_t s;
    s = idle(); s.r_out[3] = 1; s.op = f; s.zl_in = 1; s.zh_in = hi_too;
    applyStimulus(s);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [31:0] got;
    got = dut_val(e.id);
    n_vec++;
    if (got !== e.val) begin
      n_bad++;
      $display("[TB] FAIL %s %s: got %08h expected %08h at %0t",
               e.tag, reg_name(e.id), got, e.val, $time);
    end
  endtask

  // Monitor: compares whatever expectations the driver has queued.
  initial begin
    exp_t e;
    while (!done) begin
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    ctrl_t s;
    logic [4:0] valid_ops [13];
    valid_ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                  5'd11, 5'd15, 5'd16, 5'd17, 5'd18};
    s = idle();
    pc_out = 0; zh_out = 0; zl_out = 0; mdr_out = 0; r_out = '0;
    mar_in = 0; pc_in = 0; mdr_in = 0; ir_in = 0; y_in = 0; hi_in = 0;
    lo_in = 0; c_in = 0; r_in = '0; zh_in = 0; zl_in = 0; inc_pc = 0;
    rd = 0; op = '0; mdata = '0;

    // Power-on reset
    #2 Clear = 1'b0;
    for (int i = 0; i < NREG; i++) m[i] = 32'd0;
    #1 push_all("reset");
    #10 Clear = 1'b1;

    // MDR from memory, then MDR onto the bus into R2
    load_mdr(32'h12);
    expect_const(3, 32'h12, "mdr_load");
    s = idle(); s.mdr_out = 1; s.r_in[2] = 1;
    applyStimulus(s);
    expect_const(11, 32'h12, "r2_from_mdr");

    // Arithmetic shift of 0x12 by 20 clears, result copied into R1
    set_r(3, 32'h14);
    s = idle(); s.r_out[2] = 1; s.y_in = 1;
    applyStimulus(s);
    alu_r3(5'b00110, 0);
    expect_const(8, 32'h0, "shra_small");
    s = idle(); s.zl_out = 1; s.r_in[1] = 1;
    applyStimulus(s);
    expect_const(10, 32'h0, "r1_from_z");

    // Shift/rotate boundaries
    set_y(32'h8000_0000);
    set_r(3, 32'd4);
    alu_r3(5'b00110, 0);
    expect_const(8, 32'hF800_0000, "shra_neg");
    alu_r3(5'b00101, 0);
    expect_const(8, 32'h0800_0000, "shr_logical");
    set_y(32'h1);
    set_r(3, 32'd1);
    alu_r3(5'b01000, 0);
    expect_const(8, 32'h8000_0000, "ror_wrap");

    // Signed multiply and divide
    set_y(32'hFFFF_FFFD);
    set_r(3, 32'd5);
    alu_r3(5'b01111, 1);
    expect_const(8, 32'hFFFF_FFF1, "mul_lo");
    expect_const(9, 32'hFFFF_FFFF, "mul_hi");
    set_y(32'hFFFF_FFF9);
    set_r(3, 32'd2);
    alu_r3(5'b10000, 1);
    expect_const(8, 32'hFFFF_FFFD, "div_quo");
    expect_const(9, 32'hFFFF_FFFF, "div_rem");

    // PC wrap with IncPC over PCin, then PCin from MDR
    load_mdr(32'hFFFF_FFFF);
    s = idle(); s.mdr_out = 1; s.pc_in = 1;
    applyStimulus(s);
    load_mdr(32'd7);
    s = idle(); s.mdr_out = 1; s.pc_in = 1; s.inc_pc = 1;
    applyStimulus(s);
    expect_const(0, 32'h0, "pc_wrap");
    s = idle(); s.mdr_out = 1; s.pc_in = 1;
    applyStimulus(s);
    expect_const(0, 32'd7, "pc_load");

    // Clear pulsed between edges; loads attempted while low are ignored
    @(negedge Clock);
    #2 Clear = 1'b0;
    for (int i = 0; i < NREG; i++) m[i] = 32'd0;
    #1 push_all("clear_async");
    s = idle(); s.mdr_in = 1; s.rd = 1; s.mdata = 32'hABCD; s.inc_pc = 1;
    s.r_in = '1; s.y_in = 1;
    applyStimulus(s);
    #1 Clear = 1'b1;
    load_mdr(32'h55);
    expect_const(3, 32'h55, "after_clear");

    // Randomized micro-operations
    for (int n = 0; n < 300; n++) begin
      s = idle();
      s.zh_out  = ($urandom % 8) == 0;
      s.zl_out  = ($urandom % 6) == 0;
      s.mdr_out = ($urandom % 4) == 0;
      s.pc_out  = ($urandom % 6) == 0;
      s.r_out   = 6'($urandom) & 6'($urandom) & 6'($urandom);
      s.mar_in  = ($urandom % 3) == 0;
      s.pc_in   = ($urandom % 4) == 0;
      s.mdr_in  = ($urandom % 2) == 0;
      s.ir_in   = ($urandom % 3) == 0;
      s.y_in    = ($urandom % 3) == 0;
      s.hi_in   = ($urandom % 3) == 0;
      s.lo_in   = ($urandom % 3) == 0;
      s.c_in    = ($urandom % 3) == 0;
      s.r_in    = 15'($urandom) & 15'($urandom);
      s.zh_in   = ($urandom % 2) == 0;
      s.zl_in   = ($urandom % 2) == 0;
      s.inc_pc  = ($urandom % 8) == 0;
      s.rd      = ($urandom % 2) == 0;
      s.op      = (($urandom % 5) == 0) ? 5'($urandom) : valid_ops[$urandom % 13];
      s.mdata   = (($urandom % 2) == 0) ? $urandom : ($urandom % 64);
      applyStimulus(s);
    end

    #3;
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) #1;
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    done = 1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/data_path.md
DATA_PATH -- requirements
Module: data_path

Interface
REQ-001 Clock  in  1  sole clock; all state updates on rising edge.
REQ-002 Clear  in  1  asynchronous, active-low reset.
REQ-003 PCout, ZHighout, Zlowout, MDRout  in  1 each  bus-drive enables for PC, Z[63:32], Z[31:0], MDR.
REQ-004 R2out..R7out  in  1 each  bus-drive enables for R2..R7.
REQ-005 MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Cin  in  1 each  load enables for MAR, PC, MDR, IR, Y, HI, LO, C.
REQ-006 R1in..R15in  in  1 each  load enables for R1..R15.
REQ-007 ZHighIn, ZLowIn  in  1 each  load enables for Z[63:32] and Z[31:0].
REQ-008 IncPC  in  1  PC increment request.
REQ-009 Read  in  1  MDR input select: 1 = Mdatain, 0 = bus.
REQ-010 SHRA  in  5  ALU operation select.
REQ-011 Mdatain  in  32  memory read data.
REQ-012 No output ports; observability through internal 32-bit registers PC, IR, MAR, MDR, Y, HI, LO, C, R1..R15 and 64-bit Z.

Function
REQ-013 Single 32-bit internal bus; sources in fixed priority ZHighout > Zlowout > MDRout > PCout > R2out > ... > R7out; no source asserted -> bus = 0.
REQ-014 R0 is not implemented; R1, R8..R15 and HI, LO, C are load-only.
REQ-015 Each register with an enable loads bus on rising edge when enable = 1, else holds.
REQ-016 MDR loads Mdatain when MDRin = 1 and Read = 1; loads bus when MDRin = 1 and Read = 0.
REQ-017 PC: IncPC = 1 -> PC <= PC + 1 (wraps 0xFFFFFFFF -> 0), taking precedence over PCin; else PCin = 1 -> PC <= bus.
REQ-018 ALU operands: A = Y, B = bus; combinational 64-bit result; shift/rotate amount = B[4:0].
REQ-019 SHRA encoding: 00011 ADD, 00100 SUB (A-B), 00101 SHR logical, 00110 SHRA arithmetic, 00111 SHL, 01000 ROR, 01001 ROL, 01010 AND, 01011 OR, 01111 MUL signed, 10000 DIV signed, 10001 NEG (-B), 10010 NOT (~B); all other codes -> result 0.
REQ-020 32-bit ops: result[31:0] = op result mod 2^32, result[63:32] = 0; carry/overflow discarded.
REQ-021 MUL: result = full 64-bit signed product.
REQ-022 DIV: result[31:0] = quotient, result[63:32] = remainder, truncation toward zero, remainder sign follows A; B = 0 -> result 0.
REQ-023 ZLowIn = 1 -> Z[31:0] <= result[31:0]; ZHighIn = 1 -> Z[63:32] <= result[63:32]; independent, may be simultaneous.
REQ-024 Register loading a value that it drives onto the bus in the same cycle captures pre-edge value (no combinational loop).
REQ-025 Simultaneous load enables to multiple registers all capture the same bus value.

Reset
REQ-026 Clear = 0 -> immediately, independent of Clock, all registers (PC, IR, MAR, MDR, Y, Z, HI, LO, C, R1..R15) = 0.
REQ-027 While Clear = 0 all load/increment requests are ignored; first update on the first rising edge after Clear returns to 1.

Verification
REQ-028 Clear=1; Mdatain=0x12, Read=1, MDRin=1 one edge; then MDRout=1, R2in=1 one edge -> MDR = 0x12, R2 = 0x12.
REQ-029 R2=0x12, R3=0x14; R2out+Yin edge; R3out, SHRA=00110, ZLowIn edge; Zlowout+R1in edge -> Z[31:0] = 0, R1 = 0.
REQ-030 Y=0x80000000, bus R3=4, SHRA=00110, ZLowIn -> Z[31:0] = 0xF8000000; SHRA=00101 -> 0x08000000; SHRA=01000 with Y=0x1, B=1 -> 0x80000000.
REQ-031 Y=0xFFFFFFFD (-3), B=5, SHRA=01111, ZLowIn+ZHighIn -> Z = 0xFFFFFFFF_FFFFFFF1; SHRA=10000, Y=-7, B=2 -> Z[31:0]=0xFFFFFFFD, Z[63:32]=0xFFFFFFFF.
REQ-032 PC=0xFFFFFFFF, IncPC=1 and PCin=1 with MDRout (MDR=7) -> PC = 0; next edge PCin only -> PC = 7.
REQ-033 Registers loaded nonzero, Clear pulsed low between clock edges -> all registers 0 immediately, remain 0 until Clear high and new loads.
